// File: rtl/cmos_cfg_sequencer_pkg.sv
// cmos_cfg_pkg: shared definitions for the CMOS configuration sequencer.
//   - cfg_state_t : sequencer state encoding
//   - DELAY_TAG_DEF : default register address that marks an in-table delay
//   - ADDR_MSB/ADDR_LSB/VAL_MSB : field offsets inside a 24-bit LUT entry
//   - TIMEOUT_MS : write-response timeout (used only with CMOS_CFG_TIMEOUT_EN)
package cmos_cfg_pkg;

  typedef enum logic [3:0] {
    ST_PWR_HOLD,
    ST_RST_HOLD,
    ST_RST_WAIT,
    ST_FETCH,
    ST_ISSUE,
    ST_WAIT,
    ST_DELAY,
    ST_DONE,
    ST_ERR
  } cfg_state_t;

  localparam logic [15:0] DELAY_TAG_DEF = 16'hFFFF;

  localparam int unsigned ADDR_MSB = 23;
  localparam int unsigned ADDR_LSB = 8;
  localparam int unsigned VAL_MSB  = 7;

  localparam int unsigned TIMEOUT_MS = 10;

endpackage

// File: rtl/cmos_cfg_sequencer_ms_tick.sv
// cmos_ms_tick: millisecond prescaler.
//   sys_clk  in  : clock
//   sys_rstn in  : synchronous active-low reset
//   clr      in  : restart the period (counter back to 0)
//   tick     out : 1-cycle pulse when the counter reaches CLOCK_MAIN-1
module cmos_ms_tick #(
  parameter int unsigned CLOCK_MAIN = 100_000
) (
  input  logic sys_clk,
  input  logic sys_rstn,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = (CLOCK_MAIN > 1) ? $clog2(CLOCK_MAIN) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(CLOCK_MAIN - 1));

  always_ff @(posedge sys_clk) begin
    if (!sys_rstn)
      cnt <= '0;
    else if (clr || tick)
      cnt <= '0;
    else
      cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/cmos_cfg_sequencer.sv
// cmos_cfg_sequencer: CMOS sensor power-up sequencing and register-LUT walker.
//   sys_clk/sys_rstn          : clock, synchronous active-low reset
//   start                     : rerun LUT from index 0 (honoured in DONE/ERR only)
//   lut_index/lut_size/lut_data : LUT read port (data combinational from index)
//   wr_req/wr_addr/wr_data    : byte-write request to the I2C engine (level)
//   wr_ack/wr_nack            : 1-cycle completion pulses from the I2C engine
//   cmos_pwdn/cmos_rst_n      : sensor power-down (active high) and reset (active low)
//   busy/config_done/config_err/err_index : status to the capture pipeline
// Build option: define CMOS_CFG_TIMEOUT_EN to treat 10 ms of WAIT silence as a NACK.
module cmos_cfg_sequencer
  import cmos_cfg_pkg::*;
#(
  parameter int unsigned CLOCK_MAIN = 100_000,
  parameter int unsigned LUT_AW     = 9,
  parameter int unsigned PWDN_MS    = 1,
  parameter int unsigned RST_MS     = 20,
  parameter int unsigned MAX_RETRY  = 3,
  parameter logic [15:0] DELAY_TAG  = DELAY_TAG_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rstn,
  input  logic              start,
  output logic [LUT_AW-1:0] lut_index,
  input  logic [LUT_AW-1:0] lut_size,
  input  logic [23:0]       lut_data,
  output logic              wr_req,
  output logic [15:0]       wr_addr,
  output logic [7:0]        wr_data,
  input  logic              wr_ack,
  input  logic              wr_nack,
  output logic              cmos_pwdn,
  output logic              cmos_rst_n,
  output logic              busy,
  output logic              config_done,
  output logic              config_err,
  output logic [LUT_AW-1:0] err_index
);

  localparam int unsigned RW = $clog2(MAX_RETRY + 2);

  cfg_state_t    state, state_n;
  logic [23:0]   entry_q;
  logic [RW-1:0] retry_cnt;
  logic [15:0]   ms_cnt;
  logic [15:0]   ms_target;
  logic          ms_hit;
  logic          tick;
  logic          clr;
  logic          nack_eff;
  logic          at_end;

  // Every state change restarts the ms timebase, so each timed state
  // lasts exactly target * CLOCK_MAIN cycles from its entry edge.
  assign clr = (state_n != state);

  cmos_ms_tick #(.CLOCK_MAIN(CLOCK_MAIN)) u_tick (
    .sys_clk  (sys_clk),
    .sys_rstn (sys_rstn),
    .clr      (clr),
    .tick     (tick)
  );

  assign at_end = (lut_index == lut_size);

`ifdef CMOS_CFG_TIMEOUT_EN
  assign nack_eff = wr_nack ||
                    (tick && (ms_cnt == 16'(TIMEOUT_MS - 1)));
`else
  assign nack_eff = wr_nack;
`endif

  always_comb begin
    ms_target = '0;
    case (state)
      ST_PWR_HOLD: ms_target = 16'(PWDN_MS);
      ST_RST_HOLD: ms_target = 16'(RST_MS);
      ST_RST_WAIT: ms_target = 16'(RST_MS);
      ST_DELAY:    ms_target = {8'h00, entry_q[VAL_MSB:0]};
      default:     ms_target = '0;
    endcase
  end

  // A zero target completes immediately; otherwise on the last tick.
  assign ms_hit = (ms_target == '0) || (tick && (ms_cnt == ms_target - 16'd1));

  always_comb begin
    state_n = state;
    case (state)
      ST_PWR_HOLD: if (ms_hit) state_n = ST_RST_HOLD;
      ST_RST_HOLD: if (ms_hit) state_n = ST_RST_WAIT;
      ST_RST_WAIT: if (ms_hit) state_n = ST_FETCH;
      ST_FETCH: begin
        if (at_end)
          state_n = ST_DONE;
        else if (lut_data[ADDR_MSB:ADDR_LSB] == DELAY_TAG)
          state_n = ST_DELAY;
        else
          state_n = ST_ISSUE;
      end
      ST_ISSUE: state_n = ST_WAIT;
      ST_WAIT: begin
        if (nack_eff)
          state_n = (retry_cnt < RW'(MAX_RETRY)) ? ST_ISSUE : ST_ERR;
        else if (wr_ack)
          state_n = ST_FETCH;
      end
      ST_DELAY: if (ms_hit) state_n = ST_FETCH;
      ST_DONE:  if (start) state_n = ST_FETCH;
      ST_ERR:   if (start) state_n = ST_FETCH;
      default:  state_n = ST_PWR_HOLD;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rstn) begin
      state       <= ST_PWR_HOLD;
      cmos_pwdn   <= 1'b1;
      cmos_rst_n  <= 1'b0;
      wr_req      <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      lut_index   <= '0;
      busy        <= 1'b1;
      config_done <= 1'b0;
      config_err  <= 1'b0;
      err_index   <= '0;
      entry_q     <= '0;
      retry_cnt   <= '0;
      ms_cnt      <= '0;
    end else begin
      state <= state_n;

      if (clr)
        ms_cnt <= '0;
      else if (tick)
        ms_cnt <= ms_cnt + 16'd1;

      case (state)
        ST_PWR_HOLD: if (ms_hit) cmos_pwdn  <= 1'b0;
        ST_RST_HOLD: if (ms_hit) cmos_rst_n <= 1'b1;
        ST_FETCH: begin
          if (at_end) begin
            busy        <= 1'b0;
            config_done <= 1'b1;
          end else begin
            entry_q   <= lut_data;
            retry_cnt <= '0;
          end
        end
        ST_ISSUE: begin
          wr_addr <= entry_q[ADDR_MSB:ADDR_LSB];
          wr_data <= entry_q[VAL_MSB:0];
          wr_req  <= 1'b1;
        end
        ST_WAIT: begin
          if (nack_eff) begin
            wr_req <= 1'b0;
            if (retry_cnt < RW'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + RW'(1);
            end else begin
              err_index  <= lut_index;
              busy       <= 1'b0;
              config_err <= 1'b1;
            end
          end else if (wr_ack) begin
            wr_req    <= 1'b0;
            lut_index <= lut_index + LUT_AW'(1);
          end
        end
        ST_DELAY: if (ms_hit) lut_index <= lut_index + LUT_AW'(1);
        ST_DONE, ST_ERR: begin
          if (start) begin
            config_done <= 1'b0;
            config_err  <= 1'b0;
            err_index   <= '0;
            lut_index   <= '0;
            busy        <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
